// File: rtl/sha256_pkg.sv
// Shared SHA-256 schedule types, widths and the small sigma functions.
package sha256_pkg;
    localparam int WORD_W     = 32;
    localparam int BLOCK_W    = 512;
    localparam int NUM_ROUNDS = 64;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [BLOCK_W-1:0] block_t;
    typedef enum logic {IDLE, EXPAND} state_t;

    function automatic word_t small_sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction
endpackage

// File: rtl/sha256_sched_word.sv
// Combinational SHA-256 schedule word: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] mod 2^32.
import sha256_pkg::*;

module sha256_sched_word (
    input  logic [WORD_W-1:0] w_2,
    input  logic [WORD_W-1:0] w_7,
    input  logic [WORD_W-1:0] w_15,
    input  logic [WORD_W-1:0] w_16,
    output logic [WORD_W-1:0] next_word
);
    assign next_word = small_sigma1(w_2) + w_7 + small_sigma0(w_15) + w_16;
endmodule

// File: rtl/sha256_message_schedule.sv
// SHA-256 message schedule: expands each 512-bit block to W0..W63 through a 16-word sliding window.
// Optional macro SHA256_SCHED_PREFETCH_EN adds a one-block skid buffer for 64-cycle block throughput.
import sha256_pkg::*;

module sha256_message_schedule #(
    parameter int BLOCK_W    = 512,
    parameter int WORD_W     = 32,
    parameter int NUM_ROUNDS = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          sync_rst,
    input  logic [BLOCK_W-1:0]            data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    input  logic                          data_in_last,
    output logic [WORD_W-1:0]             data_out,
    output logic [$clog2(NUM_ROUNDS)-1:0] data_out_index,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic                          data_out_last_word,
    output logic                          data_out_last
);
    localparam int IDX_W = $clog2(NUM_ROUNDS);
    localparam int WIN   = BLOCK_W / WORD_W;

    state_t              state, state_d;
    logic [WORD_W-1:0]   window [WIN];
    logic [IDX_W-1:0]    t;
    logic                last_flag, rdy_q, rdy_d;
    logic                in_fire, out_fire, last_t, wrap;
    logic                load_win, load_last;
    logic [BLOCK_W-1:0]  load_blk;
    logic [WORD_W-1:0]   next_word;

    assign in_fire  = data_in_valid & data_in_ready;
    assign out_fire = data_out_valid & data_out_ready;
    assign last_t   = (t == IDX_W'(NUM_ROUNDS - 1));
    assign wrap     = out_fire & last_t;

`ifdef SHA256_SCHED_PREFETCH_EN
    logic [BLOCK_W-1:0] pf_blk;
    logic               pf_last, pf_full, pf_full_d, pf_wr;

    assign pf_wr     = in_fire & (state == EXPAND) & ~wrap;
    // A block arriving on the final handshake with the buffer empty bypasses straight into the window.
    assign load_win  = (in_fire & (state == IDLE)) | (wrap & (pf_full | in_fire));
    assign load_blk  = pf_full ? pf_blk  : data_in;
    assign load_last = pf_full ? pf_last : data_in_last;
    assign pf_full_d = pf_wr | (pf_full & ~wrap);
    assign rdy_d     = ~pf_full_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pf_full <= 1'b0;
            pf_last <= 1'b0;
            pf_blk  <= '0;
        end else if (sync_rst) begin
            pf_full <= 1'b0;
            pf_last <= 1'b0;
            pf_blk  <= '0;
        end else if (en) begin
            pf_full <= pf_full_d;
            if (pf_wr) begin
                pf_blk  <= data_in;
                pf_last <= data_in_last;
            end
        end
    end
`else
    assign load_win  = in_fire;
    assign load_blk  = data_in;
    assign load_last = data_in_last;
    // Ready re-arms one cycle after IDLE is entered, so a block period is 64 words plus two.
    assign rdy_d     = (state == IDLE) & ~in_fire;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           state <= IDLE;
        else if (sync_rst) state <= IDLE;
        else if (en)       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_fire) state_d = EXPAND;
            EXPAND:  if (wrap && !load_win) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_in_ready      = rdy_q & en & ~sync_rst;
        data_out_valid     = (state == EXPAND) & en & ~sync_rst;
        data_out           = '0;
        data_out_last_word = 1'b0;
        data_out_last      = 1'b0;
        if (state == EXPAND) begin
            data_out           = window[0];
            data_out_last_word = last_t;
            data_out_last      = last_t & last_flag;
        end
    end

    assign data_out_index = t;

    sha256_sched_word u_word (
        .w_2       (window[WIN-2]),
        .w_7       (window[WIN-7]),
        .w_15      (window[1]),
        .w_16      (window[0]),
        .next_word (next_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t         <= '0;
            last_flag <= 1'b0;
            rdy_q     <= 1'b0;
            for (int i = 0; i < WIN; i++) window[i] <= '0;
        end else if (sync_rst) begin
            t         <= '0;
            last_flag <= 1'b0;
            rdy_q     <= 1'b0;
            for (int i = 0; i < WIN; i++) window[i] <= '0;
        end else if (en) begin
            rdy_q <= rdy_d;
            if (load_win) begin
                for (int i = 0; i < WIN; i++) window[i] <= load_blk[BLOCK_W-1-WORD_W*i -: WORD_W];
                t         <= '0;
                last_flag <= load_last;
            end else if (out_fire) begin
                for (int i = 0; i < WIN-1; i++) window[i] <= window[i+1];
                window[WIN-1] <= next_word;
                t             <= last_t ? '0 : t + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sha256_message_schedule.sv
// Directed bench for sha256_message_schedule: reset, abc/all-ones vectors, backpressure, en stall, resets.
module tb_sha256_message_schedule;
    typedef logic [31:0] sched_t [64];

    logic         clk = 1'b0;
    logic         rst, en, sync_rst;
    logic [511:0] data_in;
    logic         data_in_valid, data_in_ready, data_in_last;
    logic [31:0]  data_out;
    logic [5:0]   data_out_index;
    logic         data_out_valid, data_out_ready, data_out_last_word, data_out_last;
    logic [41:0]  outs;

    int     n_assert = 0, n_fail = 0, cyc = 0;
    sched_t exp_a, exp_b, got;
    logic [511:0] blk_a, blk_b;
    int     f1, f2, l1, l2;

`ifdef SHA256_SCHED_PREFETCH_EN
    localparam int SPACING = 64;
`else
    localparam int SPACING = 66;
`endif

    sha256_message_schedule dut (
        .clk(clk), .rst(rst), .en(en), .sync_rst(sync_rst),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .data_in_last(data_in_last), .data_out(data_out), .data_out_index(data_out_index),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .data_out_last_word(data_out_last_word), .data_out_last(data_out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign outs = {data_in_ready, data_out_valid, data_out_index, data_out_last_word, data_out_last, data_out};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic model(input logic [511:0] b, output sched_t w);
        for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic rand_block(output logic [511:0] b);
        for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom;
    endtask

    task automatic send(input logic [511:0] b, input logic l);
        logic acc;
        acc = 1'b0;
        data_in = b; data_in_last = l; data_in_valid = 1'b1;
        for (int g = 0; g < 200 && !acc; g++) begin
            #1;
            if (data_in_ready) acc = 1'b1;
            @(negedge clk);
        end
        data_in_valid = 1'b0;
        check("block accept", acc, 1);
    endtask

    // Collect words k0..k1-1; every handshake is checked against the model, stalls for stability.
    task automatic recv(input sched_t expw, input logic exp_last, input int pct, input string tag,
                        input int k0, input int k1, output int first_cyc, output int last_cyc);
        int k, guard;
        logic stalled;
        logic [39:0] prev, cur, want;
        k = k0; guard = 0; stalled = 1'b0; prev = '0;
        first_cyc = -1; last_cyc = -1;
        while (k < k1 && guard < 3000) begin
            data_out_ready = ($urandom_range(99) < pct);
            #1;
            if (data_out_valid) begin
                cur = {data_out_index, data_out_last_word, data_out_last, data_out};
                if (stalled) check({tag, " stall"}, cur, prev);
                if (data_out_ready) begin
                    want = {k[5:0], k == 63, (k == 63) && exp_last, expw[k]};
                    check({tag, " word"}, cur, want);
                    got[k] = data_out;
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    prev = cur;
                end
            end
            @(negedge clk);
            guard++;
        end
        data_out_ready = 1'b0;
        check({tag, " count"}, k, k1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; sync_rst = 1'b0;
        data_in = '0; data_in_valid = 1'b0; data_in_last = 1'b0; data_out_ready = 1'b0;

        // Reset held two cycles
        @(negedge clk);
        check("reset outputs 1", outs, 0);
        @(negedge clk);
        check("reset outputs 2", outs, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle ready", data_in_ready, 1);

        // "abc" then all-ones, output ready tied high
        blk_a = {32'h61626380, 448'h0, 32'h00000018};
        blk_b = '1;
        model(blk_a, exp_a);
        model(blk_b, exp_b);
        send(blk_a, 1'b1);
`ifdef SHA256_SCHED_PREFETCH_EN
        send(blk_b, 1'b0);
`endif
        recv(exp_a, 1'b1, 100, "abc", 0, 64, f1, l1);
        check("abc W0", got[0], 32'h61626380);
        check("abc W15", got[15], 32'h00000018);
        check("abc W16", got[16], 32'h61626380);
        check("abc W17", got[17], 32'h000F0000);
        check("abc consecutive", l1 - f1, 63);
`ifndef SHA256_SCHED_PREFETCH_EN
        send(blk_b, 1'b0);
`endif
        recv(exp_b, 1'b0, 100, "ones", 0, 64, f2, l2);
        check("ones W16", got[16], 32'h203FFFFC);
        check("block spacing", f2 - f1, SPACING);

        // Two random blocks under ~50% output backpressure
        rand_block(blk_a);
        rand_block(blk_b);
        model(blk_a, exp_a);
        model(blk_b, exp_b);
        send(blk_a, 1'b0);
`ifdef SHA256_SCHED_PREFETCH_EN
        send(blk_b, 1'b1);
`endif
        recv(exp_a, 1'b0, 50, "bp blk0", 0, 64, f1, l1);
`ifndef SHA256_SCHED_PREFETCH_EN
        send(blk_b, 1'b1);
`endif
        recv(exp_b, 1'b1, 50, "bp blk1", 0, 64, f2, l2);

        // en dropped for 5 cycles at t=20
        rand_block(blk_a);
        model(blk_a, exp_a);
        send(blk_a, 1'b0);
        recv(exp_a, 1'b0, 100, "en pre", 0, 20, f1, l1);
        en = 1'b0;
        #1;
        check("en0 valid/ready", {data_out_valid, data_in_ready}, 0);
        repeat (5) @(negedge clk);
        check("en0 hold", {data_out_valid, data_out_index, data_out}, {1'b0, 6'd20, exp_a[20]});
        en = 1'b1;
        #1;
        check("en1 resume", {data_out_valid, data_out_index, data_out}, {1'b1, 6'd20, exp_a[20]});
        recv(exp_a, 1'b0, 100, "en post", 20, 64, f1, l1);

        // sync_rst at t=30
        rand_block(blk_a);
        model(blk_a, exp_a);
        send(blk_a, 1'b0);
        recv(exp_a, 1'b0, 100, "pre sync", 0, 30, f1, l1);
        sync_rst = 1'b1;
        @(negedge clk);
        sync_rst = 1'b0;
        #1;
        check("sync_rst outputs", outs, 0);
        @(negedge clk);
        check("ready after sync_rst", data_in_ready, 1);

        // async rst at t=10 of a new block, then a fresh block from index 0
        rand_block(blk_a);
        model(blk_a, exp_a);
        send(blk_a, 1'b1);
        recv(exp_a, 1'b1, 100, "pre rst", 0, 10, f1, l1);
        rst = 1'b1;
        #1;
        check("async rst outputs", outs, 0);
        @(negedge clk);
        rst = 1'b0;
        rand_block(blk_b);
        model(blk_b, exp_b);
        send(blk_b, 1'b0);
        recv(exp_b, 1'b0, 100, "post rst", 0, 64, f2, l2);
        check("post rst W0", got[0], blk_b[511:480]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end
endmodule
